// File: rtl/bitxor_cmd_seq.sv
// bitxor_cmd_seq: command sequencer in front of an 8-entry 1-bit XOR register bank.
// Takes point-update and range-query commands over a valid/ready handshake. It turns them
// into registered per-cycle bank accesses and returns range-XOR results on a second
// valid/ready port. The bank reports prefix XORs, so a range lo..hi is computed as
// prefix(hi) ^ prefix(lo-1).
// Optional feature: define BITXOR_SHADOW_CHECK_EN to keep a shadow copy of the bank. The
// bank's prefix answers are then cross-checked against it, and the sticky shadow_err
// output is added.
module bitxor_cmd_seq #(
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [IDX_W-1:0] cmd_lo,
  input  logic [IDX_W-1:0] cmd_hi,
  input  logic             cmd_val,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_data,
  output logic             rsp_err,
  output logic [1:0]       bank_inst,
  output logic [IDX_W-1:0] bank_idx,
  output logic             bank_xor,
`ifdef BITXOR_SHADOW_CHECK_EN
  output logic             shadow_err,
`endif
  input  logic             bank_rxor
);

  localparam int unsigned N = 2 ** IDX_W;

  localparam logic [1:0] InstWrite = 2'b00;
  localparam logic [1:0] InstRead  = 2'b01;

  typedef enum logic [2:0] {StIdle, StUpd, StQhi, StQlo, StRsp} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] lo_q, lo_d;
  logic             acc_q, acc_d;
  logic             err_q, err_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [1:0]       bank_inst_q, bank_inst_d;
  logic [IDX_W-1:0] bank_idx_q, bank_idx_d;
  logic             bank_xor_q, bank_xor_d;

  // Next-state logic. Bank drive values are computed one cycle ahead,
  // so the bank sees them as registered outputs.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    acc_d       = acc_q;
    err_d       = err_q;
    bank_inst_d = InstRead;
    bank_idx_d  = bank_idx_q;
    bank_xor_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          lo_d  = cmd_lo;
          acc_d = 1'b0;
          err_d = 1'b0;
          if (!cmd_op) begin
            state_d     = StUpd;
            bank_inst_d = InstWrite;
            bank_idx_d  = cmd_lo;
            bank_xor_d  = cmd_val;
          end else if (cmd_lo > cmd_hi) begin
            state_d = StRsp;
            err_d   = 1'b1;
          end else begin
            state_d    = StQhi;
            bank_idx_d = cmd_hi;
          end
        end
      end
      StUpd: begin
        state_d = StIdle;
      end
      StQhi: begin
        acc_d = bank_rxor;
        if (lo_q == '0) begin
          // Prefix(hi) already is the answer; skipping QLO avoids lo-1 underflow.
          state_d = StRsp;
        end else begin
          state_d    = StQlo;
          bank_idx_d = lo_q - IDX_W'(1);
        end
      end
      StQlo: begin
        acc_d   = acc_q ^ bank_rxor;
        state_d = StRsp;
      end
      StRsp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    cmd_ready_d = (state_d == StIdle);
  end

  // State and registered outputs; async reset drops any pending write or response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lo_q        <= '0;
      acc_q       <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      bank_inst_q <= InstRead;
      bank_idx_q  <= '0;
      bank_xor_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      bank_inst_q <= bank_inst_d;
      bank_idx_q  <= bank_idx_d;
      bank_xor_q  <= bank_xor_d;
    end
  end

  // Output mapping; response fields read as zero outside RSP.
  always_comb begin
    cmd_ready = cmd_ready_q;
    rsp_valid = (state_q == StRsp);
    rsp_data  = rsp_valid & acc_q;
    rsp_err   = rsp_valid & err_q;
    bank_inst = bank_inst_q;
    bank_idx  = bank_idx_q;
    bank_xor  = bank_xor_q;
  end

`ifdef BITXOR_SHADOW_CHECK_EN
  logic [N-1:0] shadow_q;
  logic         shadow_err_q;

  function automatic logic prefix_xor(input logic [N-1:0] v, input logic [IDX_W-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i <= int'(idx)) r = r ^ v[i];
    end
    return r;
  endfunction

  // Shadow copy tracks issued writes; any prefix disagreement latches an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= '0;
      shadow_err_q <= 1'b0;
    end else begin
      if (state_q == StUpd) begin
        shadow_q[bank_idx_q] <= shadow_q[bank_idx_q] ^ bank_xor_q;
      end
      if ((state_q == StQhi || state_q == StQlo) &&
          (bank_rxor != prefix_xor(shadow_q, bank_idx_q))) begin
        shadow_err_q <= 1'b1;
      end
    end
  end

  assign shadow_err = shadow_err_q;
`endif

endmodule

// File: tb/tb_bitxor_cmd_seq.sv
// Directed bench for bitxor_cmd_seq with a behavioural 8-entry XOR bank attached.
module tb_bitxor_cmd_seq;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [2:0] cmd_lo;
  logic [2:0] cmd_hi;
  logic       cmd_val;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_data;
  logic       rsp_err;
  logic [1:0] bank_inst;
  logic [2:0] bank_idx;
  logic       bank_xor;
  logic       bank_rxor;
`ifdef BITXOR_SHADOW_CHECK_EN
  logic       shadow_err;
`endif

  logic [7:0] mem;
  logic       inv;
  int         errors;
  int         checks;

  bitxor_cmd_seq #(.IDX_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_lo    (cmd_lo),
    .cmd_hi    (cmd_hi),
    .cmd_val   (cmd_val),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .bank_inst (bank_inst),
    .bank_idx  (bank_idx),
    .bank_xor  (bank_xor),
`ifdef BITXOR_SHADOW_CHECK_EN
    .shadow_err(shadow_err),
`endif
    .bank_rxor (bank_rxor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: write on inst 00, combinational prefix XOR (optionally corrupted).
  always @(posedge clk) begin
    if (bank_inst == 2'b00) mem[bank_idx] <= mem[bank_idx] ^ bank_xor;
  end

  always_comb begin
    bank_rxor = inv;
    for (int i = 0; i < 8; i++) begin
      if (i <= int'(bank_idx)) bank_rxor = bank_rxor ^ mem[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for cmd_ready, then presents one command for exactly one accept edge.
  task automatic send(input logic op, input logic [2:0] lo, input logic [2:0] hi,
                      input logic val);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("cmd_ready_before_send", {7'b0, cmd_ready}, 8'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_lo    = lo;
    cmd_hi    = hi;
    cmd_val   = val;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic take_rsp(input string tag, input logic data, input logic err);
    check({tag, "_valid"}, {7'b0, rsp_valid}, 8'd1);
    check({tag, "_data"}, {7'b0, rsp_data}, {7'b0, data});
    check({tag, "_err"}, {7'b0, rsp_err}, {7'b0, err});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_drop"}, {7'b0, rsp_valid}, 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors    = 0;
    checks    = 0;
    mem       = 8'h00;
    inv       = 1'b0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_lo    = 3'd0;
    cmd_hi    = 3'd0;
    cmd_val   = 1'b0;
    rsp_ready = 1'b0;

    // 1. Reset values, then full-range query on an empty bank.
    tick();
    tick();
    check("rst_cmd_ready", {7'b0, cmd_ready}, 8'd0);
    check("rst_rsp_valid", {7'b0, rsp_valid}, 8'd0);
    check("rst_rsp_data", {7'b0, rsp_data}, 8'd0);
    check("rst_rsp_err", {7'b0, rsp_err}, 8'd0);
    check("rst_bank_inst", {6'b0, bank_inst}, 8'd1);
    check("rst_bank_idx", {5'b0, bank_idx}, 8'd0);
    check("rst_bank_xor", {7'b0, bank_xor}, 8'd0);
    rst_n = 1'b1;
    tick();
    check("idle_cmd_ready", {7'b0, cmd_ready}, 8'd1);
    send(1'b1, 3'd0, 3'd7, 1'b0);
    check("q07_qhi_idx", {5'b0, bank_idx}, 8'd7);
    check("q07_qhi_inst", {6'b0, bank_inst}, 8'd1);
    check("q07_not_yet", {7'b0, rsp_valid}, 8'd0);
    check("q07_busy", {7'b0, cmd_ready}, 8'd0);
    tick();
    take_rsp("q07", 1'b0, 1'b0);

    // 2. Two updates, then ranges that see them.
    send(1'b0, 3'd3, 3'd0, 1'b1);
    check("u3_inst", {6'b0, bank_inst}, 8'd0);
    check("u3_idx", {5'b0, bank_idx}, 8'd3);
    check("u3_xor", {7'b0, bank_xor}, 8'd1);
    check("u3_no_rsp", {7'b0, rsp_valid}, 8'd0);
    tick();
    check("u3_ready_again", {7'b0, cmd_ready}, 8'd1);
    check("u3_inst_back", {6'b0, bank_inst}, 8'd1);
    check("u3_xor_back", {7'b0, bank_xor}, 8'd0);
    send(1'b0, 3'd5, 3'd0, 1'b1);
    tick();
    send(1'b1, 3'd3, 3'd5, 1'b0);
    check("q35_idx_hi", {5'b0, bank_idx}, 8'd5);
    tick();
    check("q35_idx_lo", {5'b0, bank_idx}, 8'd2);
    check("q35_not_yet", {7'b0, rsp_valid}, 8'd0);
    tick();
    take_rsp("q35", 1'b0, 1'b0);
    send(1'b1, 3'd4, 3'd7, 1'b0);
    check("q47_idx_hi", {5'b0, bank_idx}, 8'd7);
    tick();
    check("q47_idx_lo", {5'b0, bank_idx}, 8'd3);
    tick();
    take_rsp("q47", 1'b1, 1'b0);
    send(1'b1, 3'd5, 3'd5, 1'b0);
    tick();
    tick();
    take_rsp("q55", 1'b1, 1'b0);

    // 3. Rejected query: response on the very next cycle, bank untouched.
    send(1'b1, 3'd6, 3'd2, 1'b0);
    check("qerr_inst", {6'b0, bank_inst}, 8'd1);
    take_rsp("qerr", 1'b0, 1'b1);

    // 4. Consumer stall: response held, no new command accepted.
    send(1'b1, 3'd4, 3'd7, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {7'b0, rsp_valid}, 8'd1);
      check("stall_data", {7'b0, rsp_data}, 8'd1);
      check("stall_cmd_ready", {7'b0, cmd_ready}, 8'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("stall_release_ready", {7'b0, cmd_ready}, 8'd1);
    check("stall_release_valid", {7'b0, rsp_valid}, 8'd0);

    // 5. Reset during the UPD cycle cancels the write.
    send(1'b0, 3'd2, 3'd0, 1'b1);
    check("u2_inst", {6'b0, bank_inst}, 8'd0);
    rst_n = 1'b0;
    #1;
    check("u2_rst_inst", {6'b0, bank_inst}, 8'd1);
    check("u2_rst_xor", {7'b0, bank_xor}, 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(1'b1, 3'd2, 3'd2, 1'b0);
    tick();
    tick();
    take_rsp("q22", 1'b0, 1'b0);
`ifdef BITXOR_SHADOW_CHECK_EN
    check("shadow_clean", {7'b0, shadow_err}, 8'd0);
`endif

    // 6. Corrupted bank answer on a query starting at 0.
    inv = 1'b1;
    send(1'b1, 3'd0, 3'd7, 1'b0);
    tick();
    inv = 1'b0;
    take_rsp("qinv", 1'b1, 1'b0);
`ifdef BITXOR_SHADOW_CHECK_EN
    check("shadow_set", {7'b0, shadow_err}, 8'd1);
`endif
    send(1'b1, 3'd0, 3'd7, 1'b0);
    tick();
    take_rsp("qafter", 1'b0, 1'b0);
`ifdef BITXOR_SHADOW_CHECK_EN
    check("shadow_sticky", {7'b0, shadow_err}, 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
